// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared types, default parameter values and the bit-select
//               helper used by the bit serializer and its hold buffer.
// Revision    : 1.0  initial release
// ============================================================================
package serializer_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_CNT_W     = 16;
   localparam bit          DEF_MSB_FIRST = 1'b1;
   localparam bit          DEF_IDLE_BIT  = 1'b0;
   // Widest word the bit-select helper handles; words are zero-extended to it.
   localparam int unsigned MAX_W         = 64;

   // Returns the idx-th transmitted bit of a width-bit word. idx counts
   // transmission order, so idx 0 is the MSB when msb_first is set.
   function automatic logic bit_sel(input logic [MAX_W-1:0] word,
                                    input int unsigned      idx,
                                    input bit               msb_first,
                                    input int unsigned      width);
      int unsigned      pos;
      logic [MAX_W-1:0] tmp;
      pos = msb_first ? (width - 1 - idx) : idx;
      tmp = word >> pos;
      return tmp[0];
   endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/word_hold.sv
`default_nettype none
// ============================================================================
// Module      : word_hold
// Description : One-entry holding buffer. Captures a word on i_load, releases
//               it on i_unload. o_ready is registered and is low during reset
//               and for the first cycle after release.
// Ports       : clk, rst (async, active-low)
//               i_load/i_data   - write a word into the empty buffer
//               i_unload        - mark the buffered word as consumed
//               o_data, o_full  - buffered word and its occupancy flag
//               o_ready         - buffer empty and out of reset (registered)
// Revision    : 1.0  initial release
// ============================================================================
module word_hold
   import serializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_unload,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_ready
);

   logic             r_full;
   logic             r_ready;
   logic [WIDTH-1:0] r_data;
   logic             w_full_nxt;

   // A load can only happen while empty and an unload only while full,
   // so the two never collide.
   always_comb begin
      w_full_nxt = r_full;
      if (i_load)
         w_full_nxt = 1'b1;
      else if (i_unload)
         w_full_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full  <= 1'b0;
         r_ready <= 1'b0;
         r_data  <= '0;
      end else begin
         r_full  <= w_full_nxt;
         r_ready <= !w_full_nxt;
         if (i_load)
            r_data <= i_data;
      end
   end

   assign o_data  = r_data;
   assign o_full  = r_full;
   assign o_ready = r_ready;

endmodule : word_hold
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Accepts parallel words over valid/ready and emits them as a
//               gap-free one-bit-per-cycle stream. A one-entry hold buffer
//               lets the next word queue while the current one shifts.
// Ports       : clk, rst (async, active-low)
//               in_data/in_valid/in_ready - parallel word handshake
//               data_out, bit_valid       - registered serial bit + qualifier
//               busy                      - shifting or holding a word
//               words_sent                - wrapping count of finished words
// Revision    : 1.0  initial release
// ============================================================================
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter bit          MSB_FIRST = DEF_MSB_FIRST,
   parameter logic        IDLE_BIT  = DEF_IDLE_BIT,
   parameter int unsigned CNT_W     = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             data_out,
   output logic             bit_valid,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int unsigned      c_cw   = $clog2(WIDTH);
   localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_shift;
   logic [c_cw-1:0]    r_bit_cnt;
   logic               r_data_out;
   logic               r_bit_valid;
   logic [CNT_W-1:0]   r_words_sent;

   logic               w_accept;
   logic               w_last_bit;
   logic               w_hold_load;
   logic               w_hold_unload;
   logic               w_hold_full;
   logic               w_hold_ready;
   logic [WIDTH-1:0]   w_hold_data;
   logic [c_cw-1:0]    w_cnt_nxt;

   assign w_accept      = in_valid && w_hold_ready;
   assign w_last_bit    = (r_state == SHIFT) && (r_bit_cnt == c_last);
   // Mid-word accepts park in the hold buffer; an accept on the last bit
   // (hold necessarily empty) bypasses it straight into the shifter.
   assign w_hold_load   = w_accept && (r_state == SHIFT) && !w_last_bit;
   assign w_hold_unload = w_last_bit && w_hold_full;
   assign w_cnt_nxt     = r_bit_cnt + c_cw'(1);

   word_hold #(
      .WIDTH    (WIDTH)
   ) u_word_hold (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_hold_load),
      .i_data   (in_data),
      .i_unload (w_hold_unload),
      .o_data   (w_hold_data),
      .o_full   (w_hold_full),
      .o_ready  (w_hold_ready)
   );

   // data_out always presents the bit indexed by the post-edge bit_cnt, so a
   // freshly loaded word drives its first bit from the loading edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_data_out   <= IDLE_BIT;
         r_bit_valid  <= 1'b0;
         r_words_sent <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift     <= in_data;
                  r_bit_cnt   <= '0;
                  r_data_out  <= bit_sel(MAX_W'(in_data), 0, MSB_FIRST, WIDTH);
                  r_bit_valid <= 1'b1;
                  r_state     <= SHIFT;
               end else begin
                  r_data_out  <= IDLE_BIT;
                  r_bit_valid <= 1'b0;
               end
            end
            SHIFT: begin
               if (!w_last_bit) begin
                  r_bit_cnt  <= w_cnt_nxt;
                  r_data_out <= bit_sel(MAX_W'(r_shift), 32'(w_cnt_nxt),
                                        MSB_FIRST, WIDTH);
               end else begin
                  r_words_sent <= r_words_sent + CNT_W'(1);
                  r_bit_cnt    <= '0;
                  if (w_hold_full) begin
                     r_shift    <= w_hold_data;
                     r_data_out <= bit_sel(MAX_W'(w_hold_data), 0, MSB_FIRST, WIDTH);
                  end else if (w_accept) begin
                     r_shift    <= in_data;
                     r_data_out <= bit_sel(MAX_W'(in_data), 0, MSB_FIRST, WIDTH);
                  end else begin
                     r_state     <= IDLE;
                     r_data_out  <= IDLE_BIT;
                     r_bit_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_data_out  <= IDLE_BIT;
               r_bit_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = w_hold_ready;
   assign data_out   = r_data_out;
   assign bit_valid  = r_bit_valid;
   assign busy       = (r_state == SHIFT) || w_hold_full;
   assign words_sent = r_words_sent;

endmodule : bit_serializer
`default_nettype wire
